// File: rtl/wb_uart_tx_if.sv
// Capture-side bus of wb_uart_tx: the write-back word, its strobe and FIFO status.
// The pipeline (master) offers words; the UART transmitter (slave) reports its buffer state.
interface wb_uart_tx_if;
    logic [31:0] dataIn;
    logic        valid;
    logic        full;
    logic        empty;
    logic [7:0]  overflow;

    modport master (
        output dataIn,
        output valid,
        input  full,
        input  empty,
        input  overflow
    );

    modport slave (
        input  dataIn,
        input  valid,
        output full,
        output empty,
        output overflow
    );
endinterface

// File: rtl/wb_uart_tx.sv
// Buffers 32-bit write-back words in a small FIFO and sends each one as four
// UART 8N1 frames, most significant byte first, least significant bit first.
module wb_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_W       = 3
) (
    input  logic           clk,
    input  logic           reset,
    wb_uart_tx_if.slave    wb,
    output logic           tx,
    output logic           busy,
    output logic [1:0]     state_dbg_o
);

    // Capture bus: valid is a one-cycle offer with no back-pressure; a word
    // offered while full and not popping in that cycle is dropped and counted.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [7:0]        ovf_q, ovf_d;

    state_e            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              tx_q, tx_d;

    logic              pop;
    logic              push;
    logic              bit_end;
    logic [2:0]        bit_nxt;
    logic [7:0]        cur_byte;

    assign bit_end = (baud_q == BAUD_LAST);
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        cur_byte = shreg_q[31:24];
        case (byte_q)
            2'd0: cur_byte = shreg_q[31:24];
            2'd1: cur_byte = shreg_q[23:16];
            2'd2: cur_byte = shreg_q[15:8];
            2'd3: cur_byte = shreg_q[7:0];
            default: cur_byte = shreg_q[31:24];
        endcase
    end

    // tx_d is the line level for the state being entered, so tx stays registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = 16'd0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    always_comb begin
        push     = wb.valid && (!full_q || pop);
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q;
        if (wb.valid && !push && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            shreg_q  <= 32'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb.dataIn;
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;
    assign wb.full     = full_q;
    assign wb.empty    = empty_q;
    assign wb.overflow = ovf_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboarded bench for wb_uart_tx: a UART receiver decodes tx back into words
// and checks them against an expected queue filled as words are offered.
module tb_wb_uart_tx;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [1:0] state_dbg;

  wb_uart_tx_if bus ();

  wb_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (bus),
    .tx          (tx),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // scoreboard monitor: UART receiver sampling mid-bit on the falling edge
  bit          m_active = 0;
  int          m_cnt    = 0;
  int          m_nbyte  = 0;
  int          m_j;
  logic [7:0]  m_byte;
  logic [31:0] m_word;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 0;
      m_nbyte  = 0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1;
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= C / 2 && ((m_cnt - C / 2) % C) == 0) begin
        m_j = (m_cnt - C / 2) / C;
        if (m_j == 0) begin
          check("start_bit", {31'd0, tx}, 32'd0);
        end else if (m_j <= 8) begin
          m_byte[m_j-1] = tx;
        end else begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          m_word   = {m_word[23:0], m_byte};
          m_active = 0;
          m_nbyte++;
          if (m_nbyte == 4) begin
            m_nbyte = 0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_word: got 0x%0h, expected none", m_word);
            end else begin
              check("rx_word", m_word, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  bit wrap_phase = 0;
  bit saw_full   = 0;
  always @(negedge clk) if (wrap_phase && bus.full) saw_full = 1;

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w);
    bus.valid  = 1'b1;
    bus.dataIn = w;
    @(negedge clk);
    bus.valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(!busy && bus.empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'd0, n < budget}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic measure_gap();
    int n = 0;
    int g = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    while (!busy && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("idle_gap", g, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr, t0, t1, n, lows;
    reset      = 1'b1;
    bus.valid  = 1'b0;
    bus.dataIn = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_overflow", {24'd0, bus.overflow}, 32'd0);

    // single word: tx falls one edge after the write, word lasts 40 bit times
    push_word(32'h12345678);
    wr = cyc;
    n  = 0;
    while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    check("tx_fall_latency", t0 - wr, 1);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    t1 = cyc;
    check("word_length", t1 - t0, 40 * C);
    check("single_busy_end", {31'd0, busy}, 32'd0);
    check("single_empty_end", {31'd0, bus.empty}, 32'd1);
    repeat (4) @(negedge clk);

    // burst of 5, then hold valid while full; pops land at hold cycles 157 and 318
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'hA0000001 + i);
      bus.valid  = 1'b1;
      bus.dataIn = 32'hA0000001 + i;
      @(negedge clk);
    end
    check("burst_full", {31'd0, bus.full}, 32'd1);
    check("burst_overflow", {24'd0, bus.overflow}, 32'd0);
    exp_q.push_back(32'hD1D1D1D1);
    exp_q.push_back(32'hD2D2D2D2);
    for (int i = 0; i < 330; i++) begin
      bus.valid  = 1'b1;
      bus.dataIn = (i < 290) ? 32'hD1D1D1D1 : 32'hD2D2D2D2;
      @(negedge clk);
      if (i == 299) begin
        check("ovf_saturated", {24'd0, bus.overflow}, 32'd255);
        check("ovf_full_held", {31'd0, bus.full}, 32'd1);
      end
    end
    bus.valid = 1'b0;
    check("ovf_after_accept", {24'd0, bus.overflow}, 32'd255);
    check("full_after_accept", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 4; i++) measure_gap();
    wait_idle(2000);

    // reset during data bit 3 of byte 1 with two words buffered
    push_word(32'hC0FFEE01);
    push_word(32'hC0FFEE02);
    push_word(32'hC0FFEE03);
    repeat (55) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_tx", {31'd0, tx}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_empty", {31'd0, bus.empty}, 32'd1);
    check("rstmid_full", {31'd0, bus.full}, 32'd0);
    check("rstmid_overflow", {24'd0, bus.overflow}, 32'd0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rstmid_silent", lows, 0);

    // full FIFO, word offered exactly on the pop edge (edge E+162)
    for (int i = 0; i < 5; i++) push_word(32'hB0000001 + i);
    check("pp_full", {31'd0, bus.full}, 32'd1);
    repeat (157) @(negedge clk);
    check("pp_full_before", {31'd0, bus.full}, 32'd1);
    push_word(32'hB0000006);
    check("pp_full_after", {31'd0, bus.full}, 32'd1);
    check("pp_overflow", {24'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 4; i++) measure_gap();
    wait_idle(2000);

    // ten single words so both pointers wrap twice
    wrap_phase = 1;
    for (int i = 0; i < 10; i++) begin
      push_word(32'h5A000000 + 32'h01010101 * i);
      wait_idle(400);
    end
    wrap_phase = 0;
    check("wrap_never_full", {31'd0, saw_full}, 32'd0);
    check("exp_queue_empty", exp_q.size(), 0);
    check("final_overflow", {24'd0, bus.overflow}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Downstream consumer of the pipeline's write-back value (`salida`, the DatosMUX result).
- Captures 32-bit write-back words on a strobe into a small FIFO.
- Serializes each word over a UART 8N1 transmit line so results can be observed off-chip on the board.
- Decouples the 1-word-per-cycle pipeline rate from the slow serial link; words arriving while the FIFO is full are counted as overflow.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, words of buffering; power of two, 2..64.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, same clock as the pipeline.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  32  write-back value to capture.
- valid  in  1  capture strobe (tie to MEM_WB RegWrite); a word is offered on every cycle valid=1.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a word is being shifted out (any state other than IDLE).
- full  out  1  FIFO holds FIFO_DEPTH words.
- empty  out  1  FIFO holds 0 words.
- overflow  out  8  count of dropped words; saturates at 255.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, full=0, empty=1, overflow=0; FIFO pointers and count = 0; state=IDLE; bit counter, byte index and baud counter = 0.
- Reset mid-frame:
  - The frame is abandoned; tx=1 from the cycle after the reset edge.
  - All buffered words are discarded.
- FIFO:
  - Registered circular buffer; read and write pointers are ADDR_W bits and wrap modulo FIFO_DEPTH.
  - A separate count (ADDR_W+1 bits) drives full and empty, which are registered and consistent with count after every edge.
  - Write rule: a write is accepted when valid=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - Accepted words are stored in arrival order.
  - valid=1 while full and no pop: the word is dropped and overflow increments by 1, unless it is already 255.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pop on empty never occurs; the FSM only pops when empty=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0 at the edge, pop the head word into a 32-bit shift register, set byte index=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: tx=current byte bit[bit counter], LSB first, each bit held for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - if byte index<3: increment byte index, go to START;
    - if byte index=3: go to IDLE.
- Byte order: byte 0 = dataIn[31:24], then [23:16], [15:8], [7:0] (MSB byte first).
- Timing:
  - A word written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
  - tx falls at edge N+1, so it is low during cycle N+1.
  - One word occupies exactly 40*CLKS_PER_BIT cycles from the tx fall to the end of the last stop bit.
  - The FSM spends exactly 1 cycle in IDLE between consecutive words.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 on every state or bit transition.
  - Is not free-running.
- tx is driven from a register (no combinational glitches).
- busy=1 in START, DATA and STOP; busy=0 in IDLE.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, ADDR_W=2 unless noted):
- Single word:
  - Stimulus: reset 2 cycles, then valid=1 for one cycle with dataIn=0x12345678.
  - Required: tx shows 4 frames carrying bytes 0x12, 0x34, 0x56, 0x78, each as start 0, 8 data bits LSB first, stop 1, with 4 cycles per bit.
  - Required: 160 cycles from the tx fall to the end of the last stop bit; busy then returns to 0; empty=1.
- Burst and order:
  - Stimulus: valid=1 for 5 consecutive cycles with 0xA0000001..0xA0000005.
  - Required: all 5 words are accepted (the first is popped before the FIFO fills), full=1 after the 5th edge, overflow=0.
  - Required: words are transmitted in order, with 1 idle cycle between words.
- Overflow:
  - Stimulus: while transmitting with the FIFO full, hold valid=1 for 300 cycles with no pop opportunity.
  - Required: overflow saturates at 255 and full stays 1.
  - Required: after the next pop, one new word is accepted in the same cycle as the pop.
- Simultaneous push and pop:
  - Stimulus: FIFO full with the FSM entering IDLE, and valid=1 on the pop edge.
  - Required: count unchanged, overflow unchanged, and the new word is transmitted last.
- Reset mid-frame:
  - Stimulus: assert reset during the DATA bit 3 of byte 1 with 2 words buffered.
  - Required: the cycle after reset, tx=1, busy=0, empty=1, overflow=0, and nothing further is transmitted.
- Pointer wrap:
  - Stimulus: 10 words written one at a time, each after the previous word completes.
  - Required: all 10 are received correctly as pointers wrap twice; full is never asserted.
